// File: rtl/io_uart_tx.sv
// -----------------------------------------------------------------------------
// io_uart_tx
// Memory-mapped serial transmitter on the CPU IO bus. The CPU pushes bytes
// into a small FIFO through the DATA register. A four-state machine frames
// each byte as 1 start bit, 8 data bits (LSB first) and 1 stop bit on tx.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per serial bit (2..65535)
//   FIFO_DEPTH   : transmit FIFO entries (4)
//
// Ports
//   clock     in   1  rising-edge clock
//   reset     in   1  asynchronous active-high reset
//   uartcs    in   1  chip select from the IO decoder
//   uartaddr  in   2  2'b00 = DATA (write), 2'b10 = STATUS (read)
//   uartwrite in   1  IO write strobe
//   uartread  in   1  IO read strobe
//   uartwdata in  16  write data, only [7:0] used
//   uartrdata out 16  combinational read data (STATUS or zero)
//   tx        out  1  registered serial line, idle high
//
// STATUS: [0] busy, [1] fifo_empty, [2] fifo_full, [3] overflow,
//         [6:4] fifo count, [15:7] zero
// -----------------------------------------------------------------------------
module io_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        uartcs,
  input  logic [1:0]  uartaddr,
  input  logic        uartwrite,
  input  logic        uartread,
  input  logic [15:0] uartwdata,
  output logic [15:0] uartrdata,
  output logic        tx
);

  localparam int unsigned BAUD_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [1:0]        ADDR_DATA   = 2'b00;
  localparam logic [1:0]        ADDR_STATUS = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic w_push_req;
  logic w_push;
  logic w_pop;
  logic w_status_rd;
  logic w_ovf_set;
  logic w_unused_wdata;

  assign w_push_req  = uartcs & uartwrite & (uartaddr == ADDR_DATA);
  assign w_status_rd = uartcs & uartread  & (uartaddr == ADDR_STATUS);
  assign w_unused_wdata = ^uartwdata[15:8];

  // ---------------------------------------------------------------------------
  // Transmit FIFO: circular pointers wrapping modulo FIFO_DEPTH plus a count
  // ---------------------------------------------------------------------------
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_empty;
  logic [7:0]       w_head;

  assign w_full  = (r_count == CNT_FULL);
  assign w_empty = (r_count == '0);
  assign w_head  = r_mem[r_rd_ptr];

  // Fullness is judged before the edge, so a pop on the same edge does not
  // make room for the push.
  assign w_push    = w_push_req & ~w_full;
  assign w_ovf_set = w_push_req &  w_full;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= uartwdata[7:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Overflow flag: sticky until a STATUS read; a set on the same edge wins
  // ---------------------------------------------------------------------------
  logic r_ovf;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_set) begin
      r_ovf <= 1'b1;
    end else if (w_status_rd) begin
      r_ovf <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Serialiser FSM
  // ---------------------------------------------------------------------------
  state_t            r_state;
  state_t            w_state_nxt;
  logic [BAUD_W-1:0] r_baud;
  logic [BAUD_W-1:0] w_baud_nxt;
  logic [2:0]        r_bit;
  logic [2:0]        w_bit_nxt;
  logic [7:0]        r_shift;
  logic [7:0]        w_shift_nxt;
  logic              r_tx;
  logic              w_tx_nxt;
  logic              w_bit_end;

  assign w_bit_end = (r_baud == BAUD_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  // tx is computed one edge ahead from the next state so the line register
  // changes together with the state it belongs to.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_pop       = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_baud_nxt = '0;
        w_bit_nxt  = '0;
        w_tx_nxt   = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_state_nxt = S_START;
          w_tx_nxt    = 1'b0;
        end
      end

      S_START: begin
        if (w_bit_end) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = S_DATA;
          w_tx_nxt    = r_shift[0];
        end else begin
          w_baud_nxt = r_baud + BAUD_W'(1);
        end
      end

      S_DATA: begin
        if (w_bit_end) begin
          w_baud_nxt  = '0;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) begin
            w_bit_nxt   = '0;
            w_state_nxt = S_STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
            w_tx_nxt  = r_shift[1];
          end
        end else begin
          w_baud_nxt = r_baud + BAUD_W'(1);
        end
      end

      S_STOP: begin
        if (w_bit_end) begin
          w_baud_nxt = '0;
          w_bit_nxt  = '0;
          // Chain straight into the next start bit to avoid an idle gap.
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_state_nxt = S_START;
            w_tx_nxt    = 1'b0;
          end else begin
            w_state_nxt = S_IDLE;
            w_tx_nxt    = 1'b1;
          end
        end else begin
          w_baud_nxt = r_baud + BAUD_W'(1);
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_baud_nxt  = '0;
        w_bit_nxt   = '0;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  assign tx = r_tx;

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic [15:0] w_status;

  always_comb begin
    w_status      = '0;
    w_status[0]   = (r_state != S_IDLE);
    w_status[1]   = w_empty;
    w_status[2]   = w_full;
    w_status[3]   = r_ovf;
    w_status[6:4] = 3'(r_count);
  end

  assign uartrdata = w_status_rd ? w_status : '0;

endmodule

// File: tb/tb_io_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_io_uart_tx
// Directed bench for io_uart_tx with CLKS_PER_BIT = 4. Inputs change away
// from the rising edge; outputs are sampled 1 time unit after it.
// -----------------------------------------------------------------------------
module tb_io_uart_tx;

  logic        clock;
  logic        reset;
  logic        uartcs;
  logic [1:0]  uartaddr;
  logic        uartwrite;
  logic        uartread;
  logic [15:0] uartwdata;
  logic [15:0] uartrdata;
  logic        tx;

  int unsigned n_total;
  int unsigned n_pass;

  logic [7:0] ov_bytes [6];

  io_uart_tx #(
    .CLKS_PER_BIT(4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .uartcs    (uartcs),
    .uartaddr  (uartaddr),
    .uartwrite (uartwrite),
    .uartread  (uartread),
    .uartwdata (uartwdata),
    .uartrdata (uartrdata),
    .tx        (tx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected line level p cycles into a frame of byte b (4 clocks per bit).
  function automatic logic frame_bit(input logic [7:0] b, input int unsigned p);
    if (p < 4)       return 1'b0;
    else if (p < 36) return b[(p - 4) / 4];
    else             return 1'b1;
  endfunction

  // Combinational STATUS peek that does not span a clock edge.
  task automatic peek_status(input string tag, input logic [15:0] exp);
    uartwrite = 1'b0;
    uartcs    = 1'b1;
    uartread  = 1'b1;
    uartaddr  = 2'b10;
    #1;
    check(tag, uartrdata, exp);
    uartcs   = 1'b0;
    uartread = 1'b0;
    uartaddr = 2'b00;
  endtask

  // One write cycle ending on a rising edge; returns 1 unit after that edge.
  task automatic bus_write(input logic [1:0] addr, input logic [15:0] data, input logic cs);
    @(negedge clock);
    uartcs    = cs;
    uartwrite = 1'b1;
    uartaddr  = addr;
    uartwdata = data;
    @(posedge clock);
    #1;
    uartcs    = 1'b0;
    uartwrite = 1'b0;
    uartaddr  = 2'b00;
    uartwdata = '0;
  endtask

  initial begin
    int unsigned c;
    int unsigned f;
    logic        e;

    n_total   = 0;
    n_pass    = 0;
    reset     = 1'b1;
    uartcs    = 1'b0;
    uartaddr  = 2'b00;
    uartwrite = 1'b0;
    uartread  = 1'b0;
    uartwdata = '0;
    ov_bytes  = '{8'hA1, 8'h3C, 8'h0F, 8'hF0, 8'h96, 8'h77};

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst_tx", {15'd0, tx}, 16'h0001);
    peek_status("rst_status", 16'h0002);
    @(negedge clock);
    reset = 1'b0;

    // Single frame of 8'h55
    bus_write(2'b00, 16'h0055, 1'b1);
    peek_status("single_queued", 16'h0010);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock);
      #1;
      check($sformatf("single_tx_%0d", k), {15'd0, tx}, {15'd0, frame_bit(8'h55, k - 1)});
      peek_status($sformatf("single_busy_%0d", k), 16'h0003);
    end
    @(posedge clock);
    #1;
    check("single_end_tx", {15'd0, tx}, 16'h0001);
    peek_status("single_end_status", 16'h0002);

    // Overflow: six writes on consecutive edges, five back-to-back frames
    for (int cyc = 0; cyc < 246; cyc++) begin
      if (cyc < 6) begin
        uartcs    = 1'b1;
        uartwrite = 1'b1;
        uartaddr  = 2'b00;
        uartwdata = {8'h00, ov_bytes[cyc]};
      end else begin
        uartcs    = 1'b0;
        uartwrite = 1'b0;
        uartaddr  = 2'b00;
        uartwdata = '0;
      end
      @(posedge clock);
      #1;
      if (cyc >= 1) begin
        c = cyc - 1;
        f = c / 40;
        e = (f < 5) ? frame_bit(ov_bytes[f], c % 40) : 1'b1;
        check($sformatf("ovf_tx_%0d", c), {15'd0, tx}, {15'd0, e});
      end
      if (cyc == 4) peek_status("ovf_after5", 16'h0045);
      if (cyc == 5) peek_status("ovf_after6", 16'h004D);
    end
    peek_status("ovf_drained", 16'h000A);

    // Overflow clear by a real STATUS read cycle
    @(negedge clock);
    uartcs   = 1'b1;
    uartread = 1'b1;
    uartaddr = 2'b10;
    #1;
    check("ovf_read1", uartrdata, 16'h000A);
    @(posedge clock);
    #1;
    uartcs   = 1'b0;
    uartread = 1'b0;
    uartaddr = 2'b00;
    peek_status("ovf_read2", 16'h0002);

    // Reset mid-frame during DATA bit 3 with two bytes queued
    bus_write(2'b00, 16'h00F0, 1'b1);
    bus_write(2'b00, 16'h0012, 1'b1);
    bus_write(2'b00, 16'h0034, 1'b1);
    repeat (15) @(posedge clock);
    #3;
    check("midrst_bit3_tx", {15'd0, tx}, 16'h0000);
    peek_status("midrst_before", 16'h0021);
    reset = 1'b1;
    #1;
    check("midrst_async_tx", {15'd0, tx}, 16'h0001);
    peek_status("midrst_status", 16'h0002);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clock);
      #1;
      check($sformatf("midrst_idle_%0d", k), {15'd0, tx}, 16'h0001);
    end
    peek_status("midrst_after", 16'h0002);

    // Ignored accesses
    bus_write(2'b00, 16'h00AA, 1'b0);
    bus_write(2'b01, 16'h00AA, 1'b1);
    peek_status("ign_status", 16'h0002);
    for (int k = 0; k < 45; k++) begin
      @(posedge clock);
      #1;
      check($sformatf("ign_tx_%0d", k), {15'd0, tx}, 16'h0001);
    end
    peek_status("ign_status_end", 16'h0002);
    uartcs   = 1'b1;
    uartread = 1'b1;
    uartaddr = 2'b00;
    #1;
    check("data_read", uartrdata, 16'h0000);
    uartaddr = 2'b01;
    #1;
    check("reserved_read", uartrdata, 16'h0000);
    uartcs   = 1'b0;
    uartaddr = 2'b10;
    #1;
    check("nocs_status_read", uartrdata, 16'h0000);
    uartread = 1'b0;
    uartaddr = 2'b00;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/io_uart_tx.md
IO_UART_TX -- requirements
Module: io_uart_tx

Memory-mapped serial transmitter on the CPU IO bus. It is the output counterpart of the switch input port: the CPU writes bytes, and the block shifts them out on a pin.

Interface
Parameters (name, default, meaning):
- REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868: clock cycles per serial bit; legal range 2..65535.
- REQ-002 The block SHALL have parameter FIFO_DEPTH, fixed at 4: number of byte entries in the transmit FIFO.

Ports (name, direction, width, meaning):
- REQ-003 clock, input, 1: the single clock; all state updates on its rising edge.
- REQ-004 reset, input, 1: asynchronous, active-high reset.
- REQ-005 uartcs, input, 1: chip select from memorio, decoded from the high address bits.
- REQ-006 uartaddr, input, 2: low address bits; 2'b00 = DATA, 2'b10 = STATUS, others reserved.
- REQ-007 uartwrite, input, 1: IO write strobe.
- REQ-008 uartread, input, 1: IO read strobe.
- REQ-009 uartwdata, input, 16: write data; only bits [7:0] are used.
- REQ-010 uartrdata, output, 16: read data returned to the CPU.
- REQ-011 tx, output, 1: serial line; idle level is 1.

Function
- REQ-012 A push SHALL occur on a rising edge when uartcs=1, uartwrite=1 and uartaddr=2'b00; the byte uartwdata[7:0] enters the FIFO tail.
- REQ-013 When the FIFO is full before that edge, a push SHALL be dropped and the overflow flag SHALL be set; this holds even if a pop occurs on the same edge.
- REQ-014 Writes with uartcs=0, or with uartaddr other than 2'b00, SHALL have no effect.
- REQ-015 STATUS SHALL be laid out as: bit0 busy (state != IDLE), bit1 fifo_empty, bit2 fifo_full, bit3 overflow, bits[6:4] FIFO count (0..4), bits[15:7] = 0.
- REQ-016 uartrdata SHALL be combinational:
  - uartcs=1, uartread=1, uartaddr=2'b10: STATUS.
  - all other cases: 16'h0000.
  - DATA reads return 0.
- REQ-017 A STATUS read SHALL clear overflow on the rising edge that ends the read cycle; a set event on the same edge wins.
- REQ-018 The FIFO SHALL use circular read/write pointers that wrap modulo 4, with a separate 3-bit count; a simultaneous push and pop leaves the count unchanged.
- REQ-019 The state machine SHALL have four states: IDLE, START, DATA, STOP.
- REQ-020 IDLE: when the FIFO is non-empty, pop the head into an 8-bit shift register and go to START.
  - The pop SHALL happen on the edge after the byte entered an empty FIFO, giving 1 cycle of write-to-start latency.
- REQ-021 START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- REQ-022 DATA: tx = shift register bit 0 (LSB first), each bit held CLKS_PER_BIT cycles; shift right after each bit; after bit 7, go to STOP.
- REQ-023 STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
  - On the final STOP cycle, if the FIFO is non-empty, the pop and the return to START SHALL occur directly, so back-to-back frames have no idle gap.
- REQ-024 tx SHALL be driven from a register, so it changes only on clock edges and never glitches.
- REQ-025 A frame SHALL last exactly 10*CLKS_PER_BIT cycles.
- REQ-026 The baud counter SHALL count 0..CLKS_PER_BIT-1 and reset to 0 on every state or bit change.

Reset
- REQ-027 While reset=1, and immediately on its assertion (asynchronously), the block SHALL force:
  - tx=1, state=IDLE;
  - FIFO pointers and count = 0, overflow = 0;
  - baud counter and bit index = 0.
- REQ-028 Reset asserted mid-frame SHALL abort the frame (tx returns to 1 at once) and discard all queued bytes.
- REQ-029 After reset, STATUS SHALL read 16'h0002.

Verification (CLKS_PER_BIT=4)
- REQ-030 Reset check: assert reset and read STATUS -> tx=1 and uartrdata=16'h0002.
- REQ-031 Single frame: write 8'h55 at edge N ->
  - tx=0 over cycles N+1..N+4;
  - then data bits 1,0,1,0,1,0,1,0, 4 cycles each;
  - then tx=1 for 4 cycles;
  - busy=1 for 40 cycles, then STATUS=16'h0002.
- REQ-032 Overflow: write 6 bytes on consecutive edges starting from idle ->
  - after the 5th write, STATUS = 16'h0045 (count 4, full, busy);
  - the 6th write is dropped and bit3 is set;
  - exactly 5 frames go out, back-to-back with no gap.
- REQ-033 Overflow clear: read STATUS once with overflow set -> returns bit3=1; the next STATUS read returns bit3=0.
- REQ-034 Reset mid-frame: assert reset during DATA bit 3 with 2 bytes queued -> tx=1 asynchronously, STATUS=16'h0002, and no further frame after release.
- REQ-035 Ignored accesses: write with uartcs=0, or to uartaddr=2'b01 -> no frame and no STATUS change; a DATA read returns 16'h0000.
